// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and constants for the conv layer sequencer
package conv_seq_pkg;

   localparam int OC_MAX_DEF = 16;
   localparam int IC_MAX_DEF = 8;
   localparam int PERF_W     = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CONV,
      CONV_WAIT,
      POOL,
      POOL_WAIT,
      NEXT_OC,
      DONE
   } seq_state_t;

   // Counter width for a channel count; a single channel still needs one bit
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_loop_counter.sv
// rtl/seq_loop_counter.sv - loop index counter that stops at a run-time maximum
module seq_loop_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] max,
   output logic [W-1:0] count,
   output logic         at_max
);

   logic [W-1:0] r_count;

   assign at_max = (r_count == max);
   assign count  = r_count;

   // Clear wins over increment; increment is refused at the limit so the index never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && !at_max) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - out/in channel loop controller for one conv layer; CONV_SEQ_PERF_EN enables cycle_count
module conv_layer_sequencer
   import conv_seq_pkg::*;
#(
   parameter int OC_MAX = OC_MAX_DEF,
   parameter int IC_MAX = IC_MAX_DEF,
   parameter int OC_W   = clog2_min1(OC_MAX),
   parameter int IC_W   = clog2_min1(IC_MAX)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [OC_W-1:0]   cfg_oc_m1,
   input  logic [IC_W-1:0]   cfg_ic_m1,
   input  logic              cfg_pool_en,
   output logic              load_req,
   input  logic              load_ack,
   output logic              conv_start,
   input  logic              conv_done,
   output logic              pool_start,
   input  logic              pool_done,
   output logic [OC_W-1:0]   out_c,
   output logic [IC_W-1:0]   in_c,
   output logic              first_write,
   output logic              last_in_c,
   output logic              busy,
   output logic              done,
   output logic [PERF_W-1:0] cycle_count
);

   seq_state_t      r_state;
   logic [OC_W-1:0] r_oc_m1;
   logic [IC_W-1:0] r_ic_m1;
   logic            r_pool_en;
   logic            r_load_req;
   logic            r_conv_start;
   logic            r_pool_start;
   logic            r_busy;
   logic            r_done;

   logic [OC_W-1:0] w_oc_clamped;
   logic [IC_W-1:0] w_ic_clamped;
   logic [OC_W-1:0] w_out_c;
   logic [IC_W-1:0] w_in_c;
   logic            w_oc_at_max;
   logic            w_ic_at_max;
   logic            w_accept;
   logic            w_abort;
   logic            w_oc_inc;
   logic            w_ic_inc;
   logic            w_ic_clr;

   // Widths only bound the maximum when the maxima are powers of two; clamp covers the rest
   assign w_oc_clamped = (32'(cfg_oc_m1) > 32'(OC_MAX - 1)) ? OC_W'(OC_MAX - 1) : cfg_oc_m1;
   assign w_ic_clamped = (32'(cfg_ic_m1) > 32'(IC_MAX - 1)) ? IC_W'(IC_MAX - 1) : cfg_ic_m1;

   assign w_abort  = abort && (r_state != IDLE);
   assign w_accept = (r_state == IDLE) && start && !abort;
   assign w_oc_inc = (r_state == NEXT_OC) && !w_oc_at_max && !w_abort;
   assign w_ic_clr = w_accept || w_oc_inc;
   assign w_ic_inc = (r_state == CONV_WAIT) && conv_done && !w_ic_at_max && !w_abort;

   seq_loop_counter #(.W(OC_W)) u_oc_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_accept),
      .inc    (w_oc_inc),
      .max    (r_oc_m1),
      .count  (w_out_c),
      .at_max (w_oc_at_max)
   );

   seq_loop_counter #(.W(IC_W)) u_ic_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_ic_clr),
      .inc    (w_ic_inc),
      .max    (r_ic_m1),
      .count  (w_in_c),
      .at_max (w_ic_at_max)
   );

   // Sequencer FSM; strobes are registered on entry to the state they belong to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_oc_m1      <= '0;
         r_ic_m1      <= '0;
         r_pool_en    <= 1'b0;
         r_load_req   <= 1'b0;
         r_conv_start <= 1'b0;
         r_pool_start <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_conv_start <= 1'b0;
         r_pool_start <= 1'b0;
         r_done       <= 1'b0;
         if (w_abort) begin
            r_state    <= IDLE;
            r_load_req <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_accept) begin
                     r_oc_m1    <= w_oc_clamped;
                     r_ic_m1    <= w_ic_clamped;
                     r_pool_en  <= cfg_pool_en;
                     r_load_req <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= LOAD;
                  end
               end
               LOAD: begin
                  if (load_ack) begin
                     r_load_req   <= 1'b0;
                     r_conv_start <= 1'b1;
                     r_state      <= CONV;
                  end
               end
               CONV: begin
                  r_state <= CONV_WAIT;
               end
               CONV_WAIT: begin
                  if (conv_done) begin
                     if (!w_ic_at_max) begin
                        r_load_req <= 1'b1;
                        r_state    <= LOAD;
                     end else if (r_pool_en) begin
                        r_pool_start <= 1'b1;
                        r_state      <= POOL;
                     end else begin
                        r_state <= NEXT_OC;
                     end
                  end
               end
               POOL: begin
                  r_state <= POOL_WAIT;
               end
               POOL_WAIT: begin
                  if (pool_done) begin
                     r_state <= NEXT_OC;
                  end
               end
               NEXT_OC: begin
                  if (w_oc_at_max) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_load_req <= 1'b1;
                     r_state    <= LOAD;
                  end
               end
               DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign load_req    = r_load_req;
   assign conv_start  = r_conv_start;
   assign pool_start  = r_pool_start;
   assign busy        = r_busy;
   assign done        = r_done;
   assign out_c       = w_out_c;
   assign in_c        = w_in_c;
   assign first_write = (w_in_c == '0);
   assign last_in_c   = w_ic_at_max;

`ifdef CONV_SEQ_PERF_EN
   logic [PERF_W-1:0] r_cycle_count;

   // Busy-cycle counter: restarts on accept, saturates, holds while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_count <= '0;
      end else if (w_accept) begin
         r_cycle_count <= '0;
      end else if (r_busy && (r_cycle_count != '1)) begin
         r_cycle_count <= r_cycle_count + 1'b1;
      end
   end

   assign cycle_count = r_cycle_count;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - self-checking bench with channel-loop event model for conv_layer_sequencer
module tb_conv_layer_sequencer;

   localparam int OC_MAX = 16;
   localparam int IC_MAX = 8;
   localparam int OC_W   = 4;
   localparam int IC_W   = 3;
`ifdef CONV_SEQ_PERF_EN
   localparam longint EXP_CC = 7;
`else
   localparam longint EXP_CC = 0;
`endif

   typedef struct {
      int oc;
      int ic;
      bit fw;
      bit last;
   } conv_ev_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [OC_W-1:0] cfg_oc_m1 = '0;
   logic [IC_W-1:0] cfg_ic_m1 = '0;
   logic            cfg_pool_en = 1'b0;
   logic            load_req;
   logic            load_ack = 1'b0;
   logic            conv_start;
   logic            conv_done = 1'b0;
   logic            pool_start;
   logic            pool_done = 1'b0;
   logic [OC_W-1:0] out_c;
   logic [IC_W-1:0] in_c;
   logic            first_write;
   logic            last_in_c;
   logic            busy;
   logic            done;
   logic [31:0]     cycle_count;

   int checks = 0;
   int failures = 0;

   conv_ev_t conv_q[$];
   conv_ev_t load_q[$];
   int       pool_q[$];
   int       m_oc, m_ic;

   int lat = 1;
   bit spur = 0;
   int n_load, n_conv, n_pool, n_done, n_fw, n_fwlast, n_spur;

   conv_layer_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .cfg_oc_m1   (cfg_oc_m1),
      .cfg_ic_m1   (cfg_ic_m1),
      .cfg_pool_en (cfg_pool_en),
      .load_req    (load_req),
      .load_ack    (load_ack),
      .conv_start  (conv_start),
      .conv_done   (conv_done),
      .pool_start  (pool_start),
      .pool_done   (pool_done),
      .out_c       (out_c),
      .in_c        (in_c),
      .first_write (first_write),
      .last_in_c   (last_in_c),
      .busy        (busy),
      .done        (done),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Expected event stream of one run: every (oc, ic) pair in loop order, then pooling per oc
   function automatic void build_model(input int ocm, input int icm, input bit pool);
      int eo;
      int ei;
      conv_ev_t ev;
      eo = (ocm > OC_MAX - 1) ? OC_MAX - 1 : ocm;
      ei = (icm > IC_MAX - 1) ? IC_MAX - 1 : icm;
      conv_q.delete();
      load_q.delete();
      pool_q.delete();
      for (int oc = 0; oc <= eo; oc++) begin
         for (int ic = 0; ic <= ei; ic++) begin
            ev.oc = oc;
            ev.ic = ic;
            ev.fw = (ic == 0);
            ev.last = (ic == ei);
            conv_q.push_back(ev);
            load_q.push_back(ev);
         end
         if (pool) pool_q.push_back(oc);
      end
      m_oc = eo;
      m_ic = ei;
   endfunction

   // Engine responder and per-cycle compare against the model
   initial begin
      conv_ev_t ev;
      int load_wait = 0;
      int conv_cd = 0;
      int pool_cd = 0;
      bit spur_start_set = 0;
      forever begin
         @(negedge clk);
         load_ack = 1'b0;
         conv_done = 1'b0;
         pool_done = 1'b0;
         if (spur_start_set) begin
            start = 1'b0;
            spur_start_set = 0;
         end
         if (rst_n) begin
            if (conv_start) begin
               n_conv++;
               if (first_write) n_fw++;
               if (first_write && last_in_c) n_fwlast++;
               if (conv_q.size() == 0) begin
                  check("conv_unexpected", 1, 0);
               end else begin
                  ev = conv_q.pop_front();
                  check("conv_out_c", out_c, ev.oc);
                  check("conv_in_c", in_c, ev.ic);
                  check("conv_first_write", first_write, ev.fw);
                  check("conv_last_in_c", last_in_c, ev.last);
               end
            end
            if (pool_start) begin
               n_pool++;
               if (pool_q.size() == 0) check("pool_unexpected", 1, 0);
               else check("pool_out_c", out_c, pool_q.pop_front());
            end
            if (done) begin
               n_done++;
               check("done_conv_left", conv_q.size(), 0);
               check("done_pool_left", pool_q.size(), 0);
               check("done_out_c", out_c, m_oc);
               check("done_in_c", in_c, m_ic);
            end
            if (load_req) begin
               if (load_wait >= lat) begin
                  load_ack = 1'b1;
                  load_wait = 0;
                  n_load++;
                  if (load_q.size() == 0) begin
                     check("load_unexpected", 1, 0);
                  end else begin
                     ev = load_q.pop_front();
                     check("load_out_c", out_c, ev.oc);
                     check("load_in_c", in_c, ev.ic);
                  end
               end else begin
                  if (spur && load_wait == 1) begin
                     conv_done = 1'b1;
                     pool_done = 1'b1;
                     start = 1'b1;
                     spur_start_set = 1;
                     n_spur++;
                  end
                  load_wait++;
               end
            end
            if (conv_start) conv_cd = lat + 1;
            else if (conv_cd > 0) begin
               conv_cd--;
               if (conv_cd == 0) conv_done = 1'b1;
            end
            if (pool_start) pool_cd = lat + 1;
            else if (pool_cd > 0) begin
               pool_cd--;
               if (pool_cd == 0) pool_done = 1'b1;
            end
         end
      end
   end

   task automatic clear_counts();
      n_load = 0; n_conv = 0; n_pool = 0; n_done = 0;
      n_fw = 0; n_fwlast = 0; n_spur = 0;
   endtask

   task automatic kick(input int ocm, input int icm, input bit pool);
      @(negedge clk);
      cfg_oc_m1 = OC_W'(ocm);
      cfg_ic_m1 = IC_W'(icm);
      cfg_pool_en = pool;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("load_req_after_start", load_req, 1);
   endtask

   task automatic run_layer(input int ocm, input int icm, input bit pool, input int l, input bit sp,
                            input int exp_conv, input int exp_pool, input int exp_oc, input int exp_ic);
      int cyc;
      lat = l;
      spur = sp;
      build_model(ocm, icm, pool);
      check("model_conv_count", conv_q.size(), exp_conv);
      check("model_pool_count", pool_q.size(), exp_pool);
      clear_counts();
      kick(ocm, icm, pool);
      cyc = 0;
      while (n_done == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      check("run_done_count", n_done, 1);
      check("run_load_count", n_load, exp_conv);
      check("run_conv_count", n_conv, exp_conv);
      check("run_pool_count", n_pool, exp_pool);
      check("run_final_out_c", out_c, exp_oc);
      check("run_final_in_c", in_c, exp_ic);
      check("run_busy_after", busy, 0);
      check("run_done_after", done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      clear_counts();
      #12;
      check("rst_busy", busy, 0);
      check("rst_load_req", load_req, 0);
      check("rst_conv_start", conv_start, 0);
      check("rst_pool_start", pool_start, 0);
      check("rst_done", done, 0);
      check("rst_out_c", out_c, 0);
      check("rst_in_c", in_c, 0);
      check("rst_cycle_count", cycle_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2 oc x 3 ic with pooling
      run_layer(1, 2, 1, 1, 0, 6, 2, 1, 2);
      check("t1_first_write_count", n_fw, 2);

      // single input channel, no pooling
      run_layer(3, 0, 0, 1, 0, 4, 0, 3, 0);
      check("t2_fw_and_last_count", n_fwlast, 4);

      // oversize output channel request
      run_layer(31, 1, 1, 0, 0, 32, 16, 15, 1);

      // spurious conv_done/pool_done/start during LOAD
      run_layer(1, 1, 0, 2, 1, 4, 0, 1, 1);
      check("t4_spurious_events", n_spur, 4);

      // abort in CONV_WAIT of oc=0, ic=1
      lat = 1;
      spur = 0;
      build_model(1, 2, 1);
      clear_counts();
      kick(1, 2, 1);
      cyc = 0;
      while (!(conv_start && out_c == 0 && in_c == 1) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_target_reached", (cyc < 500), 1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_load_req", load_req, 0);
      check("abort_conv_start", conv_start, 0);
      check("abort_done", done, 0);
      check("abort_out_c", out_c, 0);
      check("abort_in_c", in_c, 1);
      repeat (8) @(negedge clk);
      check("abort_no_done", n_done, 0);
      check("abort_still_idle", busy, 0);

      // start and abort together in IDLE
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_load_req", load_req, 0);

      run_layer(1, 2, 1, 1, 0, 6, 2, 1, 2);

      // zero-latency 1x1 run with pooling for the cycle counter
      run_layer(0, 0, 1, 0, 0, 1, 1, 0, 0);
      check("perf_cycle_count", cycle_count, EXP_CC);

      // asynchronous reset during POOL_WAIT of oc=1
      lat = 3;
      build_model(1, 0, 1);
      clear_counts();
      kick(1, 0, 1);
      cyc = 0;
      while (!(pool_start && out_c == 1) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("reset_target_reached", (cyc < 500), 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_load_req", load_req, 0);
      check("arst_pool_start", pool_start, 0);
      check("arst_out_c", out_c, 0);
      check("arst_in_c", in_c, 0);
      check("arst_cycle_count", cycle_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("arst_no_done", n_done, 0);
      check("arst_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
